// File: rtl/bka_pkg.sv
// -----------------------------------------------------------------------------
// bka_pkg
// Shared definitions for the Brent-Kung prefix adder slice.
//   BKA_WIDTH : default operand width of the adder
//   gp_t      : one (generate, propagate) pair, the unit value carried
//               between levels of the prefix tree
//   bka_levels: number of prefix levels needed for a given width
// -----------------------------------------------------------------------------
package bka_pkg;

    localparam int BKA_WIDTH = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // A Brent-Kung tree over a power-of-two width needs log2(W) up-sweep
    // levels followed by log2(W)-1 down-sweep levels.
    function automatic int bka_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// -----------------------------------------------------------------------------
// bk_prefix_cell
// Black cell of the prefix tree: merges a high-order group (gh, ph) with the
// adjacent low-order group (gl, pl) into one combined group (g, p).
//   gh, ph : group generate/propagate of the more significant span
//   gl, pl : group generate/propagate of the less significant span
//   g, p   : generate/propagate of the merged span
// Purely combinational.
// -----------------------------------------------------------------------------
module bk_prefix_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    // The merged span generates if the high part generates on its own, or
    // if it propagates a carry generated by the low part.
    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/bka4_adder.sv
// -----------------------------------------------------------------------------
// bka4_adder
// Registered Brent-Kung parallel-prefix adder computing a + b + cin. Both the
// sum and the carry out of every bit position are registered, so downstream
// flag logic can pick up overflow and intermediate carries directly.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears all outputs
//   in_valid  : a, b and cin are meaningful this cycle
//   a, b      : unsigned operands
//   cin       : carry into bit 0
//   out_valid : s and c hold a result captured on the previous edge
//   s         : sum bits (result modulo 2^WIDTH)
//   c         : carry out of each bit; c[WIDTH-1] is the adder carry-out
// WIDTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module bka4_adder
    import bka_pkg::*;
#(
    parameter int WIDTH = BKA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    localparam int LOG2W      = $clog2(WIDTH);
    localparam int NUM_LEVELS = bka_levels(WIDTH);

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] final_p;
    logic             unused_final_p;

    assign g_bit = a & b;
    assign p_bit = a ^ b;

    // Level 0 holds the per-bit (g, p) pairs, with cin folded into bit 0 so
    // that every group generate seen by the tree already accounts for it.
    // Levels 1..LOG2W are the up-sweep at strides 1, 2, 4, ...; the
    // remaining levels are the down-sweep that fills in the positions the
    // up-sweep skipped. Nodes without a cell at a level pass straight through.
    for (genvar lv = 0; lv <= NUM_LEVELS; lv++) begin : gen_level
        gp_t [WIDTH-1:0] nodes;

        if (lv == 0) begin : gen_leaf
            for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
                if (i == 0) begin : gen_fold
                    assign nodes[i].g = g_bit[0] | (p_bit[0] & cin);
                    assign nodes[i].p = p_bit[0];
                end else begin : gen_plain
                    assign nodes[i].g = g_bit[i];
                    assign nodes[i].p = p_bit[i];
                end
            end
        end else begin : gen_tree
            localparam bit UP   = (lv <= LOG2W);
            localparam int K    = UP ? (lv - 1) : (NUM_LEVELS - lv);
            localparam int DIST = 1 << K;

            for (genvar i = 0; i < WIDTH; i++) begin : gen_node
                // Up-sweep cells sit on spans ending at multiples of 2*DIST;
                // down-sweep cells sit halfway between those, beyond the
                // first block where the prefix is already complete.
                localparam bit COMBINE = UP ?
                    (((i + 1) % (2 * DIST)) == 0) :
                    ((((i + 1) % (2 * DIST)) == DIST) && (i >= 2 * DIST));

                if (COMBINE) begin : gen_cell
                    bk_prefix_cell u_cell (
                        .gh (gen_level[lv-1].nodes[i].g),
                        .ph (gen_level[lv-1].nodes[i].p),
                        .gl (gen_level[lv-1].nodes[i-DIST].g),
                        .pl (gen_level[lv-1].nodes[i-DIST].p),
                        .g  (nodes[i].g),
                        .p  (nodes[i].p)
                    );
                end else begin : gen_pass
                    assign nodes[i] = gen_level[lv-1].nodes[i];
                end
            end
        end
    end

    // After the last level every node holds the group over bits i..0
    // including cin, so its generate is exactly the carry out of bit i.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_carry
        assign carry[i]   = gen_level[NUM_LEVELS].nodes[i].g;
        assign final_p[i] = gen_level[NUM_LEVELS].nodes[i].p;
    end

    // Group propagates of the final level are not needed by the sum.
    assign unused_final_p = ^final_p;

    assign sum = p_bit ^ {carry[WIDTH-2:0], cin};

    // Single output register stage. A cycle without in_valid only drops the
    // valid flag; the last result stays visible on s and c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            s         <= sum;
            c         <= carry;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bka4_adder.sv
// -----------------------------------------------------------------------------
// tb_bka4_adder
// Self-checking bench for bka4_adder. An arithmetic reference model predicts
// out_valid, s and c every cycle; directed vectors with hand-worked results
// pin that model, followed by exhaustive and random operand sweeps.
// -----------------------------------------------------------------------------
module tb_bka4_adder;
    import bka_pkg::*;

    localparam int WIDTH = BKA_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    int errors = 0;
    int checks = 0;
    bit compare_on = 1'b0;

    logic [WIDTH-1:0] dir_a [4] = '{4'b1001, 4'b0001, 4'b1111, 4'b1101};
    logic [WIDTH-1:0] dir_b [4] = '{4'b1100, 4'b1110, 4'b1101, 4'b1000};
    logic [WIDTH-1:0] dir_s [4] = '{4'b0101, 4'b1111, 4'b1100, 4'b0101};
    logic [WIDTH-1:0] dir_c [4] = '{4'b1000, 4'b0000, 4'b1111, 4'b1000};

    bka4_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .c         (c)
    );

    always #5 clk = ~clk;

    // Sum modulo 2^WIDTH from plain integer addition.
    function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv,
                                                 input logic cv);
        int total;
        total = int'(av) + int'(bv) + int'(cv);
        return WIDTH'(total);
    endfunction

    // Carry out of bit i: the overflow of adding only the low i+1 bits.
    function automatic logic [WIDTH-1:0] ref_carry(input logic [WIDTH-1:0] av,
                                                   input logic [WIDTH-1:0] bv,
                                                   input logic cv);
        logic [WIDTH-1:0] r;
        int mask;
        int low_sum;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask    = (1 << (i + 1)) - 1;
            low_sum = (int'(av) & mask) + (int'(bv) & mask) + int'(cv);
            r[i]    = low_sum[i+1];
        end
        return r;
    endfunction

    // Reference model of the registered outputs.
    logic             exp_valid;
    logic [WIDTH-1:0] exp_s;
    logic [WIDTH-1:0] exp_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_s     <= '0;
            exp_c     <= '0;
        end else if (in_valid) begin
            exp_valid <= 1'b1;
            exp_s     <= ref_sum(a, b, cin);
            exp_c     <= ref_carry(a, b, cin);
        end else begin
            exp_valid <= 1'b0;
        end
    end

    task automatic compare(input string name, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Model comparison on every falling edge, away from the capture edge.
    always @(negedge clk) begin
        if (compare_on) begin
            compare("model_out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
            compare("model_s", s, exp_s);
            compare("model_c", c, exp_c);
        end
    end

    task automatic checkOutput(input string name, input logic ev,
                               input logic [WIDTH-1:0] es,
                               input logic [WIDTH-1:0] ec);
        compare({name, "_out_valid"}, WIDTH'(out_valid), WIDTH'(ev));
        compare({name, "_s"}, s, es);
        compare({name, "_c"}, c, ec);
    endtask

    // Drive one cycle's inputs just after a rising edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic vv);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = vv;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'b1;

        // Reset held with live random inputs: nothing may be captured.
        repeat (3) begin
            @(posedge clk);
            #1;
            compare_on = 1'b1;
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        checkOutput("reset_hold", 1'b0, 4'b0000, 4'b0000);

        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("after_release", 1'b0, 4'b0000, 4'b0000);

        // Directed vectors, one at a time.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(dir_a[j], dir_b[j], 1'b0, 1'b1);
            applyStimulus('0, '0, 1'b0, 1'b0);
            checkOutput("directed", 1'b1, dir_s[j], dir_c[j]);
        end

        // Carry-in boundaries.
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("cin_all_ones", 1'b1, 4'b0000, 4'b1111);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("cin_zero", 1'b1, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("all_zero", 1'b1, 4'b0000, 4'b0000);

        // Back-to-back stream, then hold after in_valid drops.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(dir_a[j], dir_b[j], 1'b0, 1'b1);
            if (j > 0) checkOutput("stream", 1'b1, dir_s[j-1], dir_c[j-1]);
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("stream_last", 1'b1, dir_s[3], dir_c[3]);
        applyStimulus(4'b1010, 4'b0101, 1'b1, 1'b0);
        checkOutput("stream_hold", 1'b0, dir_s[3], dir_c[3]);

        // Asynchronous reset between edges while a result is showing.
        applyStimulus(dir_a[0], dir_b[0], 1'b0, 1'b1);
        applyStimulus(dir_a[2], dir_b[2], 1'b0, 1'b1);
        checkOutput("pre_reset", 1'b1, dir_s[0], dir_c[0]);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", 1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("post_reset_capture", 1'b1, dir_s[2], dir_c[2]);

        // Every operand combination, streamed back to back.
        for (int n = 0; n < (1 << (2 * WIDTH + 1)); n++) begin
            applyStimulus(WIDTH'(n), WIDTH'(n >> WIDTH), n[2*WIDTH], 1'b1);
        end

        // Random traffic with random gaps.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          1'($urandom_range(0, 1)));
        end

        applyStimulus('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 compare_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bka4_adder.md
Name: bka4_adder

Overview:
- Registered Brent-Kung parallel-prefix adder: a + b + cin, producing per-bit sum and per-bit carry-out vectors.
- Default width is 4 bits.
- Combinational generate/propagate prefix tree feeds a single output register stage with a valid flag.
- Used as a low-depth adder leaf in datapath blocks needing both the sum and the full carry chain (overflow, flag logic).

Parameters:
- WIDTH, 4, operand width. Must be a power of 2, at least 2; tree depth is 2*log2(WIDTH)-1 prefix levels.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/cin qualify this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry into bit 0
- out_valid  output  1  s/c hold a valid result
- s  output  WIDTH  sum bits
- c  output  WIDTH  carry-out of each bit position; c[WIDTH-1] is the adder carry-out

Behaviour:
- Reset:
  - rst_n low asynchronously clears s, c and out_valid to 0.
  - Release is synchronous to the next clk edge; no result is produced by the edge coincident with release.
- Bit-level generate and propagate: g[i]=a[i]&b[i], p[i]=a[i]^b[i].
- cin is folded into bit 0 as G0 = g[0] | (p[0]&cin).
- Prefix tree, Brent-Kung topology:
  - Up-sweep at strides 1,2,4,... computes group (G,P) for spans ending at bits 2^k-1.
  - Down-sweep fills the remaining odd positions. For WIDTH=4: level 1 cells at (1:0) and (3:2); level 2 at (3:0); level 3 at (2:0).
  - Combine rule: G = Gh | (Ph & Gl); P = Ph & Pl.
- Carry vector: c[i] = group G over bits i..0 including cin, i.e. the carry out of bit i.
- Sum: s[0] = p[0]^cin; s[i] = p[i]^c[i-1] for i>0.
- Width: the result is exact modulo 2^WIDTH; the overflow bit is c[WIDTH-1]. No saturation, no signed interpretation.
- Latency 1 cycle: on a clk edge with in_valid=1, register s and c from the current a/b/cin and set out_valid=1.
- On an edge with in_valid=0, out_valid goes 0 and s/c hold their last values.
- No backpressure; back-to-back in_valid gives one result per cycle.
- Reset asserted mid-stream discards the in-flight result; out_valid=0 until a new in_valid edge after release.
- Boundaries:
  - All-ones + 0 + cin=1 gives s=0 and c all ones (full ripple-equivalent propagate).
  - 0 + 0 + cin=0 gives s=0, c=0.
- No X-propagation guarding: inputs are don't-care when in_valid=0.

Decomposition:
- Shared package bka_pkg:
  - default width constant BKA_WIDTH=4.
  - packed struct gp_t {g, p} used throughout the tree.
- Sub-module bk_prefix_cell: inputs (Gh,Ph,Gl,Pl), outputs (G,P), combinational. Instantiated per tree node via generate loops.
- Top level holds the pre-processing (g/p, cin fold), the generated tree, sum XOR and the output register.

Test Plan:
- Reset: hold rst_n=0 with random a/b -> out_valid=0, s=0000, c=0000; deassert, no in_valid -> outputs stay 0.
- Directed, cin=0, in_valid=1, expected one cycle later:
  - a=1001 b=1100 -> s=0101 c=1000
  - a=0001 b=1110 -> s=1111 c=0000
  - a=1111 b=1101 -> s=1100 c=1111
  - a=1101 b=1000 -> s=0101 c=1000
- Carry-in propagate: a=1111 b=0000 cin=1 -> s=0000 c=1111; a=0000 b=0000 cin=1 -> s=0001 c=0000.
- Streaming: the four directed vectors on consecutive cycles -> four consecutive out_valid=1 results in order; drop in_valid -> out_valid=0 with s/c held.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> s, c, out_valid clear immediately, without waiting for a clk edge.
- Exhaustive: all 512 combinations of a, b, cin -> {c[3],s} equals a+b+cin and each c[i] equals the reference ripple carry.
